uart_reg_bank: RTL and testbench

//  Parametrised successor to the UART register mapper, sitting between the UART frame receiver and the PWM/DAC pattern engines.

---
 rtl/uart_reg_bank.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_reg_bank.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bank.sv
// uart_reg_bank: decodes UART frames into per-channel double-buffered
// (shadow/active) PWM/DAC registers, with atomic masked commit.
// Optional feature macro: UART_REG_READBACK_EN (serialised 11-byte channel
// readback towards the UART transmitter over tx_data/tx_valid/tx_ready).
module uart_reg_bank #(
   parameter int _NUM_CHANNELS = 8,
   parameter int _PAT_WIDTH    = 32
) (
   input  logic                                clk_50M,
   input  logic                                rst_n,
   input  logic [7:0]                          func_reg,
   input  logic [87:0]                         rev_bus,
   input  logic                                pack_done,
   output logic [_NUM_CHANNELS-1:0]            hs_en,
   output logic [8*_NUM_CHANNELS-1:0]          duty_bus,
   output logic [16*_NUM_CHANNELS-1:0]         dessert_bus,
   output logic [8*_NUM_CHANNELS-1:0]          pnum_bus,
   output logic [_PAT_WIDTH*_NUM_CHANNELS-1:0] pat_bus,
   output logic [8*_NUM_CHANNELS-1:0]          ls_ctrl_bus,
   output logic                                ack,
   output logic                                err,
   output logic [7:0]                          err_code,
   output logic [7:0]                          tx_data,
   output logic                                tx_valid,
   input  logic                                tx_ready
);

   localparam int N  = _NUM_CHANNELS;
   localparam int PW = _PAT_WIDTH;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef UART_REG_READBACK_EN
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_TX} state_t;
`else
   typedef enum logic {S_IDLE, S_EXEC} state_t;
`endif

   state_t        state_q, state_d;
   logic [7:0]    func_q;
   logic [87:0]   pay_q;
   logic [7:0]    pb [1:10];

   logic [7:0]    sh_hs   [N];
   logic [7:0]    sh_duty [N];
   logic [15:0]   sh_des  [N];
   logic [7:0]    sh_pnum [N];
   logic [PW-1:0] sh_pat  [N];
   logic [7:0]    sh_ls   [N];
   logic [7:0]    act_hs   [N];
   logic [7:0]    act_duty [N];
   logic [15:0]   act_des  [N];
   logic [7:0]    act_pnum [N];
   logic [PW-1:0] act_pat  [N];
   logic [7:0]    act_ls   [N];

   logic          ch_ok;
   logic [CW-1:0] ch;
   logic [31:0]   mask;
   logic [31:0]   pat_full;
   logic          do_hs, do_ls, do_commit, do_clear, do_rb;
   logic          exec_err, exec_ack;
   logic [7:0]    exec_code;
   logic          busy;
   logic          tx_last;
   logic          unused_bits;
   logic          unused_hs;

   // Split the captured payload into bytes 1..10 (byte 11 is reserved).
   always_comb begin
      for (int unsigned k = 1; k <= 10; k++) begin
         pb[k] = pay_q[8*k-1 -: 8];
      end
   end

   assign ch_ok    = (32'(pb[1]) < 32'(N));
   assign ch       = pb[1][CW-1:0];
   assign mask     = {pb[1], pb[2], pb[3], pb[4]};
   assign pat_full = {pb[7], pb[8], pb[9], pb[10]};
   assign busy     = pack_done && (state_q != S_IDLE);
   assign exec_ack = do_hs | do_ls | do_commit | do_clear;

   // Command decode, only meaningful during the single execute cycle.
   always_comb begin
      do_hs     = 1'b0;
      do_ls     = 1'b0;
      do_commit = 1'b0;
      do_clear  = 1'b0;
      do_rb     = 1'b0;
      exec_err  = 1'b0;
      exec_code = '0;
      if (state_q == S_EXEC) begin
         case (func_q)
            8'h01: begin
               if (ch_ok) do_hs = 1'b1;
               else begin exec_err = 1'b1; exec_code = 8'h02; end
            end
            8'h02: begin
               if (ch_ok) do_ls = 1'b1;
               else begin exec_err = 1'b1; exec_code = 8'h02; end
            end
            8'h03: do_commit = 1'b1;
`ifdef UART_REG_READBACK_EN
            8'h04: begin
               if (ch_ok) do_rb = 1'b1;
               else begin exec_err = 1'b1; exec_code = 8'h02; end
            end
`endif
            8'h05: do_clear = 1'b1;
            default: begin exec_err = 1'b1; exec_code = 8'h01; end
         endcase
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (pack_done) state_d = S_EXEC;
`ifdef UART_REG_READBACK_EN
         S_EXEC: state_d = do_rb ? S_TX : S_IDLE;
         S_TX:   if (tx_last) state_d = S_IDLE;
`else
         S_EXEC: state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State register and frame capture (frames are only accepted when idle).
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         func_q  <= '0;
         pay_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && pack_done) begin
            func_q <= func_reg;
            pay_q  <= rev_bus;
         end
      end
   end

   // Shadow/active register bank: shadows take writes, actives only change on commit/clear.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < N; c++) begin
            sh_hs[c]    <= '0; sh_duty[c]  <= '0; sh_des[c]  <= '0;
            sh_pnum[c]  <= '0; sh_pat[c]   <= '0; sh_ls[c]   <= '0;
            act_hs[c]   <= '0; act_duty[c] <= '0; act_des[c] <= '0;
            act_pnum[c] <= '0; act_pat[c]  <= '0; act_ls[c]  <= '0;
         end
      end else if (do_clear) begin
         for (int unsigned c = 0; c < N; c++) begin
            sh_hs[c]    <= '0; sh_duty[c]  <= '0; sh_des[c]  <= '0;
            sh_pnum[c]  <= '0; sh_pat[c]   <= '0; sh_ls[c]   <= '0;
            act_hs[c]   <= '0; act_duty[c] <= '0; act_des[c] <= '0;
            act_pnum[c] <= '0; act_pat[c]  <= '0; act_ls[c]  <= '0;
         end
      end else begin
         if (do_hs) begin
            sh_hs[ch]   <= pb[2];
            sh_duty[ch] <= pb[3];
            sh_des[ch]  <= {pb[4], pb[5]};
            sh_pnum[ch] <= pb[6];
            sh_pat[ch]  <= pat_full[PW-1:0];
         end
         if (do_ls) sh_ls[ch] <= pb[2];
         if (do_commit) begin
            for (int unsigned c = 0; c < N; c++) begin
               if (mask[c]) begin
                  act_hs[c]   <= sh_hs[c];
                  act_duty[c] <= sh_duty[c];
                  act_des[c]  <= sh_des[c];
                  act_pnum[c] <= sh_pnum[c];
                  act_pat[c]  <= sh_pat[c];
                  act_ls[c]   <= sh_ls[c];
               end
            end
         end
      end
   end

   // Ack/err pulses; a busy drop is the newest error so its code wins a tie.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         ack      <= 1'b0;
         err      <= 1'b0;
         err_code <= '0;
      end else begin
         ack <= exec_ack | tx_last;
         err <= exec_err | busy;
         if (busy)          err_code <= 8'h03;
         else if (exec_err) err_code <= exec_code;
      end
   end

   // Drive the active-register buses.
   always_comb begin
      for (int unsigned c = 0; c < N; c++) begin
         hs_en[c]              = act_hs[c][0];
         duty_bus[8*c +: 8]    = act_duty[c];
         dessert_bus[16*c +: 16] = act_des[c];
         pnum_bus[8*c +: 8]    = act_pnum[c];
         pat_bus[PW*c +: PW]   = act_pat[c];
         ls_ctrl_bus[8*c +: 8] = act_ls[c];
      end
   end

   // Upper hs_ctrl bits are only observable through readback.
   always_comb begin
      unused_hs = 1'b0;
      for (int unsigned c = 0; c < N; c++) begin
         unused_hs = unused_hs ^ (^act_hs[c][7:1]);
      end
   end

   assign unused_bits = ^{pay_q[87:80], pat_full, tx_ready};

`ifdef UART_REG_READBACK_EN
   logic [87:0] snap_q;
   logic [3:0]  tx_idx_q;
   logic [31:0] rb_pat;

   assign rb_pat   = 32'(act_pat[ch]);
   assign tx_valid = (state_q == S_TX);
   assign tx_data  = tx_valid ? snap_q[8*tx_idx_q +: 8] : '0;
   assign tx_last  = tx_valid && tx_ready && (tx_idx_q == 4'd10);

   // Snapshot the active channel at execute time, then step through bytes on each handshake.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         snap_q   <= '0;
         tx_idx_q <= '0;
      end else if (do_rb) begin
         snap_q   <= {rb_pat[7:0], rb_pat[15:8], rb_pat[23:16], rb_pat[31:24],
                      act_pnum[ch], act_des[ch][7:0], act_des[ch][15:8],
                      act_duty[ch], act_hs[ch], pb[1], 8'h84};
         tx_idx_q <= '0;
      end else if (tx_valid && tx_ready) begin
         tx_idx_q <= tx_idx_q + 4'd1;
      end
   end
`else
   assign tx_valid = 1'b0;
   assign tx_data  = '0;
   assign tx_last  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_reg_bank.sv
// tb_uart_reg_bank: directed and randomized frames against a per-channel
// shadow/active reference model. Honours UART_REG_READBACK_EN when defined.
`timescale 1ns/1ps
module tb_uart_reg_bank;
   localparam int N  = 8;
   localparam int PW = 32;

   logic            clk_50M   = 1'b0;
   logic            rst_n     = 1'b0;
   logic [7:0]      func_reg  = '0;
   logic [87:0]     rev_bus   = '0;
   logic            pack_done = 1'b0;
   logic            tx_ready  = 1'b0;
   logic [N-1:0]    hs_en;
   logic [8*N-1:0]  duty_bus;
   logic [16*N-1:0] dessert_bus;
   logic [8*N-1:0]  pnum_bus;
   logic [PW*N-1:0] pat_bus;
   logic [8*N-1:0]  ls_ctrl_bus;
   logic            ack, err;
   logic [7:0]      err_code;
   logic [7:0]      tx_data;
   logic            tx_valid;

   always #10 clk_50M = ~clk_50M;

   uart_reg_bank #(._NUM_CHANNELS(N), ._PAT_WIDTH(PW)) dut (
      .clk_50M(clk_50M), .rst_n(rst_n), .func_reg(func_reg), .rev_bus(rev_bus),
      .pack_done(pack_done), .hs_en(hs_en), .duty_bus(duty_bus),
      .dessert_bus(dessert_bus), .pnum_bus(pnum_bus), .pat_bus(pat_bus),
      .ls_ctrl_bus(ls_ctrl_bus), .ack(ack), .err(err), .err_code(err_code),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   typedef struct {
      logic [7:0]  hs;
      logic [7:0]  duty;
      logic [15:0] des;
      logic [7:0]  pnum;
      logic [31:0] pat;
      logic [7:0]  ls;
   } chan_t;

   chan_t      m_sh [N];
   chan_t      m_act[N];
   logic [7:0] m_code = '0;
   int         total = 0;
   int         bad   = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [87:0] mk(input logic [7:0] b1, b2, b3, b4, b5,
                                      input logic [7:0] b6, b7, b8, b9, b10);
      return {8'h00, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1};
   endfunction

   task automatic m_reset();
      for (int c = 0; c < N; c++) begin
         m_sh[c]  = '{default: '0};
         m_act[c] = '{default: '0};
      end
      m_code = '0;
   endtask

   // Reference semantics of one executed frame (readback handled separately).
   task automatic m_exec(input logic [7:0] f, input logic [87:0] p,
                         output bit e_ack, output bit e_err);
      logic [7:0]  b[1:11];
      logic [31:0] msk;
      int          ch;
      for (int k = 1; k <= 11; k++) b[k] = p[8*k-1 -: 8];
      ch    = int'(b[1]);
      e_ack = 0;
      e_err = 0;
      case (f)
         8'h01: if (ch < N) begin
                   m_sh[ch].hs = b[2]; m_sh[ch].duty = b[3]; m_sh[ch].des = {b[4], b[5]};
                   m_sh[ch].pnum = b[6]; m_sh[ch].pat = {b[7], b[8], b[9], b[10]};
                   e_ack = 1;
                end else begin e_err = 1; m_code = 8'h02; end
         8'h02: if (ch < N) begin m_sh[ch].ls = b[2]; e_ack = 1; end
                else begin e_err = 1; m_code = 8'h02; end
         8'h03: begin
                   msk = {b[1], b[2], b[3], b[4]};
                   for (int c = 0; c < N; c++) if (msk[c]) m_act[c] = m_sh[c];
                   e_ack = 1;
                end
         8'h05: begin
                   for (int c = 0; c < N; c++) begin
                      m_sh[c] = '{default: '0}; m_act[c] = '{default: '0};
                   end
                   e_ack = 1;
                end
         default: begin e_err = 1; m_code = 8'h01; end
      endcase
   endtask

   task automatic chk_buses(input string tag);
      logic [255:0] e_hs, e_du, e_de, e_pn, e_pa, e_ls;
      e_hs = '0; e_du = '0; e_de = '0; e_pn = '0; e_pa = '0; e_ls = '0;
      for (int c = 0; c < N; c++) begin
         e_hs[c]           = m_act[c].hs[0];
         e_du[8*c +: 8]    = m_act[c].duty;
         e_de[16*c +: 16]  = m_act[c].des;
         e_pn[8*c +: 8]    = m_act[c].pnum;
         e_pa[PW*c +: PW]  = m_act[c].pat[PW-1:0];
         e_ls[8*c +: 8]    = m_act[c].ls;
      end
      chk({tag, ".hs_en"}, hs_en, e_hs);
      chk({tag, ".duty"}, duty_bus, e_du);
      chk({tag, ".dessert"}, dessert_bus, e_de);
      chk({tag, ".pnum"}, pnum_bus, e_pn);
      chk({tag, ".pat"}, pat_bus, e_pa);
      chk({tag, ".ls"}, ls_ctrl_bus, e_ls);
   endtask

   // One frame: pack_done at T, nothing visible at T+1, result at T+2.
   task automatic frame(input string tag, input logic [7:0] f, input logic [87:0] p);
      bit ea, ee;
      @(negedge clk_50M);
      func_reg = f; rev_bus = p; pack_done = 1'b1;
      @(negedge clk_50M);
      pack_done = 1'b0;
      chk({tag, ".ack_early"}, ack, 1'b0);
      m_exec(f, p, ea, ee);
      @(negedge clk_50M);
      chk({tag, ".ack"}, ack, ea);
      chk({tag, ".err"}, err, ee);
      chk({tag, ".err_code"}, err_code, m_code);
      chk_buses(tag);
   endtask

`ifdef UART_REG_READBACK_EN
   task automatic readback(input logic [7:0] ch, input bit inject);
      logic [7:0] exp_q[$];
      logic [7:0] got_q[$];
      logic [7:0] hold_d;
      bit         hold_v;
      int         cyc;
      exp_q = {8'h84, ch, m_act[ch].hs, m_act[ch].duty, m_act[ch].des[15:8],
               m_act[ch].des[7:0], m_act[ch].pnum, m_act[ch].pat[31:24],
               m_act[ch].pat[23:16], m_act[ch].pat[15:8], m_act[ch].pat[7:0]};
      @(negedge clk_50M);
      func_reg = 8'h04; rev_bus = mk(ch, 0, 0, 0, 0, 0, 0, 0, 0, 0); pack_done = 1'b1;
      @(negedge clk_50M);
      pack_done = 1'b0;
      chk("rb.valid_early", tx_valid, 1'b0);
      hold_v = 0; hold_d = '0; cyc = 0;
      while (got_q.size() < 11 && cyc < 200) begin
         @(negedge clk_50M);
         cyc++;
         if (inject && cyc == 3) begin
            func_reg = 8'h01; rev_bus = mk(8'h00, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
            pack_done = 1'b1;
         end else begin
            pack_done = 1'b0;
         end
         if (inject && cyc == 4) begin
            chk("rb.busy_err", err, 1'b1);
            chk("rb.busy_code", err_code, 8'h03);
            m_code = 8'h03;
         end
         if (hold_v) begin
            chk("rb.valid_held", tx_valid, 1'b1);
            chk("rb.data_stable", tx_data, hold_d);
         end
         if (tx_valid && got_q.size() == 10) chk("rb.ack_before_last", ack, 1'b0);
         tx_ready = (cyc % 2 == 1);
         hold_v   = tx_valid && !tx_ready;
         hold_d   = tx_data;
         if (tx_valid && tx_ready) got_q.push_back(tx_data);
      end
      @(negedge clk_50M);
      pack_done = 1'b0;
      tx_ready  = 1'b0;
      chk("rb.byte_count", got_q.size(), 11);
      chk("rb.ack", ack, 1'b1);
      chk("rb.valid_after", tx_valid, 1'b0);
      chk("rb.err_code", err_code, m_code);
      for (int i = 0; i < got_q.size() && i < 11; i++)
         chk($sformatf("rb.byte%0d", i), got_q[i], exp_q[i]);
   endtask
`endif

   initial begin
      bit         ea, ee;
      logic [7:0] f, rb[1:10];
      logic [31:0] msk;
      int         op;

      // Reset state
      m_reset();
      repeat (3) @(negedge clk_50M);
      chk("rst.ack", ack, 1'b0);
      chk("rst.err", err, 1'b0);
      chk("rst.err_code", err_code, 8'h00);
      chk("rst.tx_valid", tx_valid, 1'b0);
      chk("rst.tx_data", tx_data, 8'h00);
      chk_buses("rst");
      rst_n = 1'b1;

      // HS write to ch2 leaves actives untouched until the commit
      frame("hs_ch2", 8'h01, mk(8'h02, 8'h01, 8'h10, 8'h00, 8'h32, 8'h05, 8'h01, 8'hFF, 8'hFF, 8'hFF));
      frame("commit_ch2", 8'h03, mk(8'h00, 8'h00, 8'h00, 8'h04, 0, 0, 0, 0, 0, 0));

      // Errors: channel out of range, unknown function
      frame("bad_ch", 8'h01, mk(8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99));
      frame("bad_func", 8'h7F, mk(8'h02, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      frame("recommit_ch2", 8'h03, mk(8'h00, 8'h00, 8'h00, 8'h04, 0, 0, 0, 0, 0, 0));

      // Two shadows, all-ones mask (bits >= N ignored)
      frame("hs_ch0", 8'h01, mk(8'h00, 8'h03, 8'h20, 8'h12, 8'h34, 8'h07, 8'hDE, 8'hAD, 8'hBE, 8'hEF));
      frame("hs_ch1", 8'h01, mk(8'h01, 8'h00, 8'h30, 8'hAB, 8'hCD, 8'h09, 8'h12, 8'h34, 8'h56, 8'h78));
      frame("ls_ch1", 8'h02, mk(8'h01, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 0));
      frame("commit_all", 8'h03, mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0));
      frame("commit_zero", 8'h03, mk(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));

      // Back-to-back frames: second is dropped as busy, both pulses fire together
      @(negedge clk_50M);
      func_reg = 8'h01; rev_bus = mk(8'h03, 8'h01, 8'h44, 8'h00, 8'h10, 8'h02, 0, 0, 0, 8'h0F);
      pack_done = 1'b1;
      m_exec(func_reg, rev_bus, ea, ee);
      @(negedge clk_50M);
      func_reg = 8'h02; rev_bus = mk(8'h03, 8'hC3, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk_50M);
      pack_done = 1'b0;
      m_code = 8'h03;
      chk("busy.ack", ack, 1'b1);
      chk("busy.err", err, 1'b1);
      chk("busy.err_code", err_code, 8'h03);
      frame("commit_ch3", 8'h03, mk(8'h00, 8'h00, 8'h00, 8'h08, 0, 0, 0, 0, 0, 0));

`ifdef UART_REG_READBACK_EN
      readback(8'h02, 1'b1);
      readback(8'h01, 1'b0);
      frame("rb_bad_ch", 8'h04, mk(8'h09, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Reset in the middle of a readback
      @(negedge clk_50M);
      func_reg = 8'h04; rev_bus = mk(8'h02, 0, 0, 0, 0, 0, 0, 0, 0, 0); pack_done = 1'b1;
      @(negedge clk_50M);
      pack_done = 1'b0; tx_ready = 1'b0;
      @(negedge clk_50M);
      chk("rbrst.valid_before", tx_valid, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      m_reset();
      chk("rbrst.tx_valid", tx_valid, 1'b0);
      chk("rbrst.tx_data", tx_data, 8'h00);
      chk("rbrst.err_code", err_code, 8'h00);
      chk_buses("rbrst");
`else
      frame("rb_disabled", 8'h04, mk(8'h02, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tx_ready = 1'b1;
      @(negedge clk_50M);
      chk("rbdis.tx_valid", tx_valid, 1'b0);
      chk("rbdis.tx_data", tx_data, 8'h00);
      tx_ready = 1'b0;

      // Reset while a command is executing
      @(negedge clk_50M);
      func_reg = 8'h05; rev_bus = '0; pack_done = 1'b1;
      @(negedge clk_50M);
      pack_done = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      m_reset();
      chk("midrst.err_code", err_code, 8'h00);
      chk("midrst.ack", ack, 1'b0);
      chk_buses("midrst");
`endif
      @(negedge clk_50M);
      rst_n = 1'b1;
      frame("post_rst_hs", 8'h01, mk(8'h05, 8'h01, 8'h77, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h12, 8'h34));
      frame("post_rst_commit", 8'h03, mk(8'h00, 8'h00, 8'h00, 8'h20, 0, 0, 0, 0, 0, 0));

      // Randomized frames against the model
      for (int it = 0; it < 80; it++) begin
         for (int k = 1; k <= 10; k++) rb[k] = 8'($urandom_range(0, 255));
         op = $urandom_range(0, 9);
         case (op)
            0, 1, 2: begin f = 8'h01; rb[1] = 8'($urandom_range(0, 9)); end
            3, 4:    begin f = 8'h02; rb[1] = 8'($urandom_range(0, 9)); end
            5, 6, 7: begin
                        f = 8'h03;
                        msk = $urandom;
                        {rb[1], rb[2], rb[3], rb[4]} = msk;
                     end
            8:       f = ($urandom_range(0, 5) == 0) ? 8'h05 : 8'h03;
            default: f = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(6, 255));
         endcase
         frame($sformatf("rnd%0d_f%0h", it, f), f,
               mk(rb[1], rb[2], rb[3], rb[4], rb[5], rb[6], rb[7], rb[8], rb[9], rb[10]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
